// File: rtl/block_xfer_seq.sv
// LDM/STM block transfer sequencer: walks a 16-bit register list, one memory word per register.
// Optional base writeback is compiled in with `define BLOCK_XFER_WB_EN.
module block_xfer_seq #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              up,
    input  logic              pre,
    input  logic              writeback,
    input  logic [3:0]        base_reg,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [15:0]       reg_list,
    output logic              busy,
    output logic              done,
    output logic              hold_pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        ARm,
    input  logic [DATA_W-1:0] Rm,
    output logic [3:0]        ARd,
    output logic              wen_ARd,
    output logic [DATA_W-1:0] Rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_LWR,
`ifdef BLOCK_XFER_WB_EN
        S_BASEWB,
`endif
        S_DONE
    } state_t;

    state_t            state_q, state_d, after_last;
    logic              load_q, load_d;
    logic              up_q, up_d;
    logic              pre_q, pre_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [15:0]       list_q, list_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

`ifdef BLOCK_XFER_WB_EN
    logic              wb_q, wb_d;
    logic [3:0]        breg_q, breg_d;
    logic              wbgo_q, wbgo_d;
    logic [DATA_W-1:0] wbval_q, wbval_d;
`else
    logic              unused_wb_cfg;
    assign unused_wb_cfg = ^{writeback, base_reg};
`endif

    logic [3:0]        cur;
    logic [15:0]       rest;
    logic [4:0]        cnt;
    logic [DATA_W-1:0] n4;

    // list_q holds the registers still to transfer; cur is its lowest set bit
    always_comb begin
        cur = '0;
        cnt = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (list_q[i-1]) cur = 4'(i - 1);
        end
        for (int unsigned i = 0; i < 16; i++) begin
            cnt = cnt + 5'(list_q[i]);
        end
        rest = list_q & (list_q - 16'd1);
        n4   = DATA_W'(cnt) << 2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            up_q    <= 1'b0;
            pre_q   <= 1'b0;
            base_q  <= '0;
            list_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef BLOCK_XFER_WB_EN
            wb_q    <= 1'b0;
            breg_q  <= '0;
            wbgo_q  <= 1'b0;
            wbval_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            up_q    <= up_d;
            pre_q   <= pre_d;
            base_q  <= base_d;
            list_q  <= list_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef BLOCK_XFER_WB_EN
            wb_q    <= wb_d;
            breg_q  <= breg_d;
            wbgo_q  <= wbgo_d;
            wbval_q <= wbval_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        up_d      = up_q;
        pre_d     = pre_q;
        base_d    = base_q;
        list_d    = list_q;
        addr_d    = addr_q;
        data_d    = data_q;
        busy      = (state_q != S_IDLE);
        hold_pc   = (state_q != S_IDLE);
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ARm       = '0;
        ARd       = '0;
        wen_ARd   = 1'b0;
        Rd_data   = '0;
`ifdef BLOCK_XFER_WB_EN
        wb_d       = wb_q;
        breg_d     = breg_q;
        wbgo_d     = wbgo_q;
        wbval_d    = wbval_q;
        after_last = wbgo_q ? S_BASEWB : S_DONE;
`else
        after_last = S_DONE;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_d  = is_load;
                    up_d    = up;
                    pre_d   = pre;
                    base_d  = base_addr;
                    list_d  = reg_list;
`ifdef BLOCK_XFER_WB_EN
                    wb_d    = writeback;
                    breg_d  = base_reg;
`endif
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // Transfers always ascend, so decrementing modes start at the lowest address
                if (up_q) addr_d = pre_q ? base_q + DATA_W'(4) : base_q;
                else      addr_d = pre_q ? base_q - n4 : base_q - n4 + DATA_W'(4);
`ifdef BLOCK_XFER_WB_EN
                wbval_d = up_q ? base_q + n4 : base_q - n4;
                wbgo_d  = wb_q && !(load_q && list_q[breg_q]);
`endif
                state_d = (cnt == 5'd0) ? S_DONE : S_XFER;
            end
            S_XFER: begin
                mem_req  = 1'b1;
                mem_we   = !load_q;
                mem_addr = addr_q;
                if (!load_q) begin
                    ARm       = cur;
                    mem_wdata = Rm;
                end
                if (mem_ack) begin
                    if (load_q) begin
                        data_d  = mem_rdata;
                        state_d = S_LWR;
                    end else begin
                        list_d  = rest;
                        addr_d  = addr_q + DATA_W'(4);
                        state_d = (rest == 16'd0) ? after_last : S_XFER;
                    end
                end
            end
            S_LWR: begin
                wen_ARd = 1'b1;
                ARd     = cur;
                Rd_data = data_q;
                list_d  = rest;
                addr_d  = addr_q + DATA_W'(4);
                state_d = (rest == 16'd0) ? after_last : S_XFER;
            end
`ifdef BLOCK_XFER_WB_EN
            S_BASEWB: begin
                wen_ARd = 1'b1;
                ARd     = breg_q;
                Rd_data = wbval_q;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/block_xfer_seq.md
# block_xfer_seq

Multi-register transfer sequencer (LDM/STM) sitting between the core's control path, the register file's write/read ports and the data memory. It walks a 16-bit register list lowest-to-highest, reading registers via the `ARm`/`Rm` port for stores, or writing `ARd`/`wen_ARd`/`Rd_data` for loads. It optionally writes back the updated base register. The sequencer also freezes PC advance while it owns the register file.

## Interface
- `DATA_W`, 32, register/memory data and address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request, accepted only in IDLE.
- `is_load` in 1: 1 = LDM, 0 = STM. Sampled with `start`.
- `up` in 1: 1 = increment, 0 = decrement. Sampled with `start`.
- `pre` in 1: 1 = before (IB/DB), 0 = after (IA/DA). Sampled with `start`.
- `writeback` in 1: update base register. Sampled with `start`.
- `base_reg` in 4: base register index. Sampled with `start`.
- `base_addr` in DATA_W: base register value. Sampled with `start`.
- `reg_list` in 16: bit i = register i. Sampled with `start`.
- `busy` out 1: high from the cycle after accepted `start` through DONE.
- `done` out 1: one-cycle completion pulse.
- `hold_pc` out 1: equals `busy`; the core must not advance PC while it is high.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = store.
- `mem_addr` out DATA_W: word address.
- `mem_wdata` out DATA_W: store data.
- `mem_ack` in 1: request completes this cycle.
- `mem_rdata` in DATA_W: load data, valid with `mem_ack`.
- `ARm` out 4: register read index.
- `Rm` in DATA_W: combinational read data for `ARm`.
- `ARd` out 4: register write index.
- `wen_ARd` out 1: register write enable.
- `Rd_data` out DATA_W: register write data.

## Operation
- **States:** IDLE, SETUP, XFER, LWR, BASEWB, DONE.
- **IDLE:**
  - On `start`, latch all sampled inputs and go to SETUP.
  - `start` in any other state is ignored.
- **SETUP (1 cycle):** compute N = popcount(`reg_list`) and the start address A0:
  - IA: A0 = base.
  - IB: A0 = base+4.
  - DA: A0 = base-4N+4.
  - DB: A0 = base-4N.
- **Transfer order:** registers are always taken ascending; addresses always ascend by 4 per transfer.
- **Writeback value:** base+4N if `up`, else base-4N. All arithmetic is modulo 2^DATA_W.
- **Empty list (N = 0):** SETUP goes to DONE. No memory access, no register write, no writeback.
- **XFER:**
  - `mem_req`=1, `mem_addr` = current address, `mem_we` = !is_load.
  - For a store: `ARm` = current register and `mem_wdata` = `Rm`.
  - Outputs are held stable until `mem_ack`.
  - On ack, a store advances to the next set bit, or to BASEWB/DONE after the last.
  - On ack, a load captures `mem_rdata` and goes to LWR.
- **LWR (1 cycle):**
  - `wen_ARd`=1, `ARd` = current register, `Rd_data` = captured data.
  - Then go to the next XFER, or to BASEWB/DONE after the last.
  - Loading r15 is allowed; the register file takes it as the PC write.
- **BASEWB (1 cycle):** `wen_ARd`=1, `ARd`=`base_reg`, `Rd_data` = writeback value.
  - Skipped when `writeback`=0.
  - Skipped for a load whose list contains `base_reg`; the loaded value wins.
  - A store whose list contains `base_reg` stores the original base value, because the write occurs after all transfers.
- **DONE (1 cycle):** `done`=1, then go to IDLE.
- **Quiet outputs:** `mem_wdata`, `ARm`, `ARd`, `Rd_data` are 0 whenever they are not being driven per the rules above.

## Timing
- **Reset values:** on `rst`, state goes to IDLE immediately and every output is 0.
- **Reset mid-operation:** abandons the transfer with no further memory or register writes; completed writes stand.
- **Latency:**
  - `start` at cycle 0 gives SETUP at cycle 1 and the first XFER at cycle 2.
  - With zero-wait memory (`mem_ack` in the first request cycle), a store costs 1 cycle per register and a load costs 2.
  - BASEWB adds 1 cycle, DONE adds 1.
  - Zero-wait STM with N registers, no writeback: `done` at cycle 2+N.
- **Memory stall:** `mem_ack` with `mem_req`=0 is ignored. Wait states of any length hold XFER.
- **`busy`/`hold_pc`:** high from cycle 1 through the DONE cycle inclusive.
- **No overlap:** `wen_ARd` is never high in the same cycle as `mem_req`.

## Configuration
- `BLOCK_XFER_WB_EN`:
  - Defined: base writeback and the BASEWB state are implemented as above.
  - Undefined: `writeback` is ignored, BASEWB is absent, and the last transfer goes directly to DONE.

## Test plan
- **Zero-wait STMIA store:** `reg_list`=0x000E, base=0x20, R1..R3 = 0x11/0x22/0x33, `writeback`=1, `base_reg`=13 -> stores 0x11@0x20, 0x22@0x24, 0x33@0x28; r13 written 0x2C; `done` at cycle 6.
- **LDMDB load with 2-cycle memory wait:** `reg_list`=0x8003, base=0x40, `writeback`=0 -> reads 0x34, 0x38, 0x3C; writes r0, r1, r15 in order; no base write; `mem_req` held steady through the waits.
- **LDM with base in list:** base_reg=2, `reg_list`=0x0004, `writeback`=1, mem returns 0xDEAD -> r2 = 0xDEAD; BASEWB is skipped.
- **Empty list and ignored start:** `reg_list`=0 -> `done` at cycle 2 with no `mem_req` and no `wen_ARd`; a `start` pulsed while `busy` has no effect.
- **Reset mid-transfer:** `rst` asserted during the second XFER of a 4-register load -> all outputs 0 immediately; no further writes; IDLE accepts a new `start` after release.
- **Macro undefined:** the first scenario rerun without `BLOCK_XFER_WB_EN` -> no r13 write; `done` at cycle 5.
